// File: rtl/neuron_mac_engine.sv
// Dot-product engine: streams pixel/weight memories, one saturated 16-bit result per output neuron.
// Optional RELU_EN macro clamps stored results at zero.
module neuron_mac_engine #(
   parameter int NUM_PIXELS  = 784,
   parameter int NUM_OUTPUTS = 10,
   parameter int PIX_AW      = 10,
   parameter int WT_AW       = 13,
   parameter int ACC_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_calc,
   input  logic              clear_data,
   output logic [PIX_AW-1:0] pix_raddr,
   input  logic [7:0]        pix_rdata,
   output logic [WT_AW-1:0]  wt_raddr,
   input  logic [15:0]       wt_rdata,
   input  logic [3:0]        output_address,
   output logic [15:0]       result_output,
   output logic              done_calc,
   output logic              overflow
);

   localparam int DATA_W = 8;
   localparam int COEF_W = 16;
   localparam int PROD_W = DATA_W + COEF_W + 1;
   localparam int RES_W  = 16;
   localparam int O_W    = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
   localparam logic signed [ACC_W-1:0] ACC_HI = ACC_W'((2 ** (RES_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] ACC_LO = ACC_W'(-(2 ** (RES_W - 1)));

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_STORE, S_DONE} state_t;

   state_t                    state_q, state_d;
   logic [PIX_AW-1:0]         p_q;
   logic [WT_AW-1:0]          wt_addr_q;
   logic [O_W-1:0]            o_q;
   logic                      p_last, o_last, start_ok;
   logic                      vld_p1;
   logic signed [ACC_W-1:0]   acc_p1;
   logic signed [PROD_W-1:0]  prod_p0;
   logic signed [RES_W-1:0]   res_q [NUM_OUTPUTS];
   logic signed [RES_W-1:0]   store_val;
   logic                      store_clip;
   logic                      ovf_q;

   function automatic logic clip_hi(input logic signed [ACC_W-1:0] a);
      return a > ACC_HI;
   endfunction

   function automatic logic clip_lo(input logic signed [ACC_W-1:0] a);
      return a < ACC_LO;
   endfunction

   function automatic logic signed [RES_W-1:0] sat_res(input logic signed [ACC_W-1:0] a);
      if (clip_hi(a))      return {1'b0, {(RES_W-1){1'b1}}};
      else if (clip_lo(a)) return {1'b1, {(RES_W-1){1'b0}}};
      else                 return a[RES_W-1:0];
   endfunction

   assign p_last   = (p_q == PIX_AW'(NUM_PIXELS - 1));
   assign o_last   = (o_q == O_W'(NUM_OUTPUTS - 1));
   assign start_ok = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_calc;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start_calc) state_d = S_RUN;
         S_RUN:          if (p_last) state_d = S_DRAIN;
         S_DRAIN:        state_d = S_STORE;
         S_STORE:        state_d = o_last ? S_DONE : S_RUN;
         default:        state_d = S_IDLE;
      endcase
      if (clear_data) state_d = S_IDLE;
   end

   always_comb begin
      done_calc = (state_q == S_DONE);
      overflow  = ovf_q;
      pix_raddr = p_q;
      wt_raddr  = wt_addr_q;
   end

   // Address generation: weight address tracks o*NUM_PIXELS+p incrementally
   always_ff @(posedge clk) begin
      if (rst || clear_data) begin
         p_q       <= '0;
         o_q       <= '0;
         wt_addr_q <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_calc) begin
                  p_q       <= '0;
                  o_q       <= '0;
                  wt_addr_q <= '0;
               end
            end
            S_RUN: begin
               if (!p_last) begin
                  p_q       <= p_q + 1'b1;
                  wt_addr_q <= wt_addr_q + 1'b1;
               end
            end
            S_STORE: begin
               p_q <= '0;
               if (o_last) begin
                  o_q       <= '0;
                  wt_addr_q <= '0;
               end else begin
                  o_q       <= o_q + 1'b1;
                  wt_addr_q <= wt_addr_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Stage p0: memory read data arrives one cycle after the address
   assign prod_p0 = PROD_W'($signed({1'b0, pix_rdata})) * PROD_W'($signed(wt_rdata));

   always_comb begin
      store_val  = sat_res(acc_p1);
      store_clip = clip_hi(acc_p1) | clip_lo(acc_p1);
`ifdef RELU_EN
      if (acc_p1[ACC_W-1]) store_val = '0;
      store_clip = clip_hi(acc_p1);
`endif
   end

   // Stage p1: accumulate while the delayed RUN flag is set, store on STORE
   always_ff @(posedge clk) begin
      if (rst || clear_data) begin
         vld_p1 <= 1'b0;
         acc_p1 <= '0;
         ovf_q  <= 1'b0;
         for (int i = 0; i < NUM_OUTPUTS; i++) res_q[i] <= '0;
      end else begin
         vld_p1 <= (state_q == S_RUN);
         if (start_ok) begin
            acc_p1 <= '0;
            ovf_q  <= 1'b0;
         end else if (state_q == S_STORE) begin
            for (int i = 0; i < NUM_OUTPUTS; i++)
               if (o_q == O_W'(i)) res_q[i] <= store_val;
            if (store_clip) ovf_q <= 1'b1;
            acc_p1 <= '0;
         end else if (vld_p1) begin
            acc_p1 <= acc_p1 + ACC_W'(prod_p0);
         end
      end
   end

   always_comb begin
      result_output = '0;
      for (int i = 0; i < NUM_OUTPUTS; i++)
         if (output_address == 4'(i)) result_output = res_q[i];
   end

endmodule

// File: tb/tb_neuron_mac_engine.sv
// Scoreboard bench for neuron_mac_engine (4 pixels, 2 outputs) with 1-cycle model memories.
// Reference results come from a plain-arithmetic dot product; RELU_EN is honoured if defined.
module tb_neuron_mac_engine;

   localparam int NP = 4;
   localparam int NO = 2;

   logic        tb_clk = 1'b0;
   logic        rst, start_calc, clear_data;
   logic [9:0]  pix_raddr;
   logic [7:0]  pix_rdata;
   logic [2:0]  wt_raddr;
   logic [15:0] wt_rdata;
   logic [3:0]  output_address;
   logic [15:0] result_output;
   logic        done_calc, overflow;

   logic [7:0]         pix_mem [NP];
   logic signed [15:0] wt_mem  [NP*NO];
   int edge_cnt = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic signed [15:0] r0;
      logic signed [15:0] r1;
      logic               ovf;
      logic               done;
      int                 edge_n;
   } exp_t;

   exp_t exp_q[$];
   exp_t snap_q[$];
   exp_t prev;

   always #5 tb_clk = ~tb_clk;

   neuron_mac_engine #(
      .NUM_PIXELS(NP), .NUM_OUTPUTS(NO), .PIX_AW(10), .WT_AW(3), .ACC_W(32)
   ) dut (
      .clk(tb_clk), .rst(rst), .start_calc(start_calc), .clear_data(clear_data),
      .pix_raddr(pix_raddr), .pix_rdata(pix_rdata), .wt_raddr(wt_raddr), .wt_rdata(wt_rdata),
      .output_address(output_address), .result_output(result_output),
      .done_calc(done_calc), .overflow(overflow)
   );

   always @(posedge tb_clk) begin
      edge_cnt  <= edge_cnt + 1;
      pix_rdata <= (pix_raddr < 10'(NP)) ? pix_mem[pix_raddr[1:0]] : 8'd0;
      wt_rdata  <= wt_mem[wt_raddr];
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic read_res(input logic [3:0] a, output int v);
      output_address = a;
      #1;
      v = int'($signed(result_output));
   endtask

   function automatic exp_t ref_run();
      exp_t e;
      int   s;
      e = '{default: 0};
      for (int o = 0; o < NO; o++) begin
         s = 0;
         for (int p = 0; p < NP; p++) s += int'(pix_mem[p]) * int'(wt_mem[o*NP + p]);
`ifdef RELU_EN
         if (s < 0) s = 0;
`endif
         if (s > 32767) begin
            s = 32767;
            e.ovf = 1'b1;
         end else if (s < -32768) begin
            s = -32768;
            e.ovf = 1'b1;
         end
         if (o == 0) e.r0 = 16'(s);
         else        e.r1 = 16'(s);
      end
      e.done = 1'b1;
      return e;
   endfunction

   initial begin : monitor
      logic done_prev;
      exp_t e;
      int   v;
      done_prev      = 1'b0;
      output_address = 4'd0;
      forever begin
         @(negedge tb_clk);
         if (snap_q.size() > 0) begin
            e = snap_q.pop_front();
            read_res(4'd0, v); chk("snap_result0", v, int'(e.r0));
            read_res(4'd1, v); chk("snap_result1", v, int'(e.r1));
            chk("snap_overflow", int'(overflow), int'(e.ovf));
            chk("snap_done", int'(done_calc), int'(e.done));
         end
         if (done_calc && !done_prev) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=1 required=0 at edge %0d", edge_cnt);
            end else begin
               e = exp_q.pop_front();
               chk("done_edge", edge_cnt, e.edge_n);
               read_res(4'd0, v); chk("result0", v, int'(e.r0));
               read_res(4'd1, v); chk("result1", v, int'(e.r1));
               chk("overflow", int'(overflow), int'(e.ovf));
               read_res(4'd5, v); chk("result_addr5", v, 0);
               read_res(4'd15, v); chk("result_addr15", v, 0);
            end
         end
         done_prev = done_calc;
      end
   end

   task automatic push_snap(input exp_t base);
      exp_t s;
      s      = base;
      s.ovf  = 1'b0;
      s.done = 1'b0;
      snap_q.push_back(s);
   endtask

   task automatic start_run(output exp_t e);
      e        = ref_run();
      e.edge_n = edge_cnt + 13;
      exp_q.push_back(e);
      start_calc = 1'b1;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200; i++) begin
         @(posedge tb_clk); #2;
         if (done_calc) return;
      end
      checks++;
      errors++;
      $display("FAIL wait_done actual=timeout required=done_calc at edge %0d", edge_cnt);
   endtask

   task automatic do_run();
      exp_t e;
      start_run(e);
      @(posedge tb_clk); #2;
      start_calc = 1'b0;
      @(posedge tb_clk); #2;
      push_snap(prev);
      wait_done();
      prev = e;
      @(posedge tb_clk); #2;
   endtask

   task automatic fill(input int pv, input int wv0, input int wv1);
      for (int p = 0; p < NP; p++) begin
         pix_mem[p]   = 8'(pv);
         wt_mem[p]    = 16'(wv0);
         wt_mem[NP+p] = 16'(wv1);
      end
   endtask

   task automatic fill_random(input bit extreme);
      for (int p = 0; p < NP; p++) pix_mem[p] = extreme ? 8'd255 : 8'($urandom_range(0, 255));
      for (int i = 0; i < NP*NO; i++)
         wt_mem[i] = extreme ? (($urandom_range(0, 1) == 1) ? 16'sh7FFF : 16'sh8000) : 16'($urandom);
   endtask

   task automatic abort_checks(input string tag);
      void'(exp_q.pop_back());
      chk({tag, "_pix_raddr"}, int'(pix_raddr), 0);
      chk({tag, "_wt_raddr"}, int'(wt_raddr), 0);
      chk({tag, "_done"}, int'(done_calc), 0);
      chk({tag, "_overflow"}, int'(overflow), 0);
      prev = '{default: 0};
      push_snap(prev);
   endtask

   initial begin : stimulus
      exp_t e, e2;
      rst        = 1'b1;
      start_calc = 1'b0;
      clear_data = 1'b0;
      prev       = '{default: 0};
      fill(0, 0, 0);
      repeat (3) @(posedge tb_clk);
      #2 rst = 1'b0;
      chk("reset_pix_raddr", int'(pix_raddr), 0);
      chk("reset_wt_raddr", int'(wt_raddr), 0);
      chk("reset_done", int'(done_calc), 0);
      chk("reset_overflow", int'(overflow), 0);
      push_snap(prev);
      @(posedge tb_clk); #2;

      fill(1, 1, 1);
      do_run();
      fill(255, 32767, 32767);
      do_run();
      fill(255, -32768, -32768);
      do_run();
      for (int p = 0; p < NP; p++) begin
         pix_mem[p]   = 8'(p + 1);
         wt_mem[p]    = 16'sd1;
         wt_mem[NP+p] = -16'sd1;
      end
      do_run();

      // clear_data sampled at the 6th edge of a run
      fill_random(1'b0);
      start_run(e);
      @(posedge tb_clk); #2;
      start_calc = 1'b0;
      repeat (5) @(posedge tb_clk);
      #2 clear_data = 1'b1;
      @(posedge tb_clk); #2;
      clear_data = 1'b0;
      abort_checks("clear");
      repeat (20) @(posedge tb_clk);
      #2;
      do_run();

      // start_calc held through a whole run, then one more cycle
      fill_random(1'b0);
      start_run(e);
      wait_done();
      e2        = ref_run();
      e2.edge_n = edge_cnt + 13;
      exp_q.push_back(e2);
      @(posedge tb_clk); #2;
      start_calc = 1'b0;
      chk("restart_done_drop", int'(done_calc), 0);
      wait_done();
      prev = e2;
      @(posedge tb_clk); #2;

      // rst sampled at the 5th edge of a run
      fill_random(1'b0);
      start_run(e);
      @(posedge tb_clk); #2;
      start_calc = 1'b0;
      repeat (4) @(posedge tb_clk);
      #2 rst = 1'b1;
      @(posedge tb_clk); #2;
      rst = 1'b0;
      abort_checks("rst");
      @(posedge tb_clk); #2;
      do_run();

      for (int k = 0; k < 8; k++) begin
         fill_random($urandom_range(0, 3) == 0);
         do_run();
      end

      repeat (3) @(posedge tb_clk);
      chk("pending_expected", exp_q.size(), 0);
      chk("pending_snapshots", snap_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
